// File: rtl/score_digit_renderer.sv
// Score field renderer: binary score -> BCD (sequential double-dabble), frame-synchronous commit,
// pixel -> glyph-ROM address mapping. Optional macro SCORE_ZERO_BLANK_EN blanks leading zeros.
module score_digit_renderer #(
  parameter logic [9:0]  ORIGIN_X   = 10'd560,
  parameter logic [9:0]  ORIGIN_Y   = 10'd20,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CELL_W     = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [13:0] i_score,
  input  logic        i_score_valid,
  output logic        o_score_ready,
  input  logic        i_frame_start,
  input  logic [9:0]  i_pix_x,
  input  logic [9:0]  i_pix_y,
  output logic [4:0]  o_sym_x,
  output logic [5:0]  o_sym_y,
  output logic [3:0]  o_sym_type,
  input  logic        i_sym_dot,
  output logic        o_pixel_on
);

  // state  | meaning
  // IDLE   | ready for a new score
  // CONV   | 14 double-dabble steps, r_cnt counts down to 0
  // PEND   | BCD complete, waiting for frame start to commit
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_PEND} state_t;

  localparam logic [9:0]  FIELD_W    = 10'(NUM_DIGITS * CELL_W);
  localparam logic [9:0]  GLYPH_H    = 10'd40;
  localparam logic [4:0]  GLYPH_W    = 5'd30;
  localparam logic [3:0]  TYPE_BLANK = 4'd10;
  localparam logic [3:0]  CONV_LAST  = 4'd13;
  localparam logic [13:0] SCORE_MAX  = 14'd9999;

  state_t      r_state;
  logic        r_ready;
  logic [3:0]  r_cnt;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [15:0] r_disp;  // [15:12] is the leftmost (most significant) cell
  logic        r_glyph_q;
  logic [4:0]  r_sym_x;
  logic [5:0]  r_sym_y;
  logic [3:0]  r_sym_type;
  logic        r_pixel_on;

  logic [13:0] w_score_sat;
  logic [15:0] w_bcd_adj;
  logic [15:0] w_disp_next;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic        w_in_field;
  logic        w_glyph;
  logic [3:0]  w_digit;

  assign w_score_sat = (i_score > SCORE_MAX) ? SCORE_MAX : i_score;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_disp_next = r_bcd;
`ifdef SCORE_ZERO_BLANK_EN
    // Blank leading zeros; the units cell always shows a digit
    if (r_bcd[15:12] == 4'd0) begin
      w_disp_next[15:12] = TYPE_BLANK;
      if (r_bcd[11:8] == 4'd0) begin
        w_disp_next[11:8] = TYPE_BLANK;
        if (r_bcd[7:4] == 4'd0) w_disp_next[7:4] = TYPE_BLANK;
      end
    end
`else
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_cnt   <= 4'd0;
      r_bin   <= 14'd0;
      r_bcd   <= 16'd0;
      r_disp  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_score_valid && r_ready) begin
            r_bin   <= w_score_sat;
            r_bcd   <= 16'd0;
            r_cnt   <= CONV_LAST;
            r_ready <= 1'b0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
          if (r_cnt == 4'd0) r_state <= S_PEND;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_PEND: begin
          if (i_frame_start) begin
            r_disp  <= w_disp_next;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Field bounds rely on the origin placement never wrapping 10 bits
  assign w_dx       = i_pix_x - ORIGIN_X;
  assign w_dy       = i_pix_y - ORIGIN_Y;
  assign w_in_field = (i_pix_x >= ORIGIN_X) && (w_dx < FIELD_W) &&
                      (i_pix_y >= ORIGIN_Y) && (w_dy < GLYPH_H);
  assign w_glyph    = w_in_field && (w_dx[4:0] < GLYPH_W);

  always_comb begin
    case (w_dx[6:5])
      2'd0:    w_digit = r_disp[15:12];
      2'd1:    w_digit = r_disp[11:8];
      2'd2:    w_digit = r_disp[7:4];
      default: w_digit = r_disp[3:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sym_x    <= 5'd0;
      r_sym_y    <= 6'd0;
      r_sym_type <= TYPE_BLANK;
      r_glyph_q  <= 1'b0;
      r_pixel_on <= 1'b0;
    end else begin
      if (w_glyph) begin
        r_sym_x    <= w_dx[4:0];
        r_sym_y    <= w_dy[5:0];
        r_sym_type <= w_digit;
      end else begin
        r_sym_x    <= 5'd0;
        r_sym_y    <= 6'd0;
        r_sym_type <= TYPE_BLANK;
      end
      r_glyph_q  <= w_glyph;
      r_pixel_on <= i_sym_dot & r_glyph_q;
    end
  end

  assign o_score_ready = r_ready;
  assign o_sym_x       = r_sym_x;
  assign o_sym_y       = r_sym_y;
  assign o_sym_type    = r_sym_type;
  assign o_pixel_on    = r_pixel_on;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench for score_digit_renderer: conversion, commit timing, field mapping, mid-conversion reset.
module tb_score_digit_renderer;

  localparam int OX = 560;
  localparam int OY = 20;
`ifdef SCORE_ZERO_BLANK_EN
  localparam int L = 10;
`else
  localparam int L = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] score;
  logic        score_valid;
  logic        score_ready;
  logic        frame_start;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [4:0]  sym_x;
  logic [5:0]  sym_y;
  logic [3:0]  sym_type;
  logic        sym_dot;
  logic        pixel_on;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in glyph ROM: a simple function of the address
  function automatic int rom(input int x, input int y, input int t);
    return ((x & 1) ^ ((y >> 1) & 1) ^ (t & 1));
  endfunction

  assign sym_dot = sym_x[0] ^ sym_y[1] ^ sym_type[0];

  score_digit_renderer dut (
    .i_clk(clk), .i_rst(rst),
    .i_score(score), .i_score_valid(score_valid), .o_score_ready(score_ready),
    .i_frame_start(frame_start), .i_pix_x(pix_x), .i_pix_y(pix_y),
    .o_sym_x(sym_x), .o_sym_y(sym_y), .o_sym_type(sym_type),
    .i_sym_dot(sym_dot), .o_pixel_on(pixel_on)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y, input int et, input int ex, input int ey, input bit eg);
    pix_x = 10'(x);
    pix_y = 10'(y);
    tick();
    chk($sformatf("sym_type(%0d,%0d)", x, y), int'(sym_type), et);
    chk($sformatf("sym_x(%0d,%0d)", x, y), int'(sym_x), ex);
    chk($sformatf("sym_y(%0d,%0d)", x, y), int'(sym_y), ey);
    tick();
    chk($sformatf("pixel_on(%0d,%0d)", x, y), int'(pixel_on), eg ? rom(ex, ey, et) : 0);
  endtask

  task automatic digits(input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) probe(OX + 32*i + 3, OY + 10, e[i], 3, 10, 1'b1);
  endtask

  // Accept a score, check a frame pulse on the last CONV cycle is ignored, commit on the first PEND cycle
  task automatic send(input int val);
    chk("ready_idle", int'(score_ready), 1);
    score = 14'(val);
    score_valid = 1'b1;
    tick();
    chk("ready_conv", int'(score_ready), 0);
    score = 14'h3FFF;
    repeat (13) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ready_pend", int'(score_ready), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    score_valid = 1'b0;
    chk("ready_commit", int'(score_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    score = '0;
    score_valid = 1'b0;
    frame_start = 1'b0;
    pix_x = '0;
    pix_y = '0;
    repeat (3) tick();
    chk("rst_ready", int'(score_ready), 1);
    chk("rst_sym_type", int'(sym_type), 10);
    chk("rst_sym_x", int'(sym_x), 0);
    chk("rst_sym_y", int'(sym_y), 0);
    chk("rst_pixel_on", int'(pixel_on), 0);
    rst = 1'b0;

    probe(OX + 5, OY + 5, 0, 5, 5, 1'b1);

    send(1234);
    digits(1, 2, 3, 4);

    probe(OX + 29,      OY + 5,  1,  29, 5,  1'b1);
    probe(OX + 30,      OY + 5,  10, 0,  0,  1'b0);
    probe(OX + 31,      OY + 5,  10, 0,  0,  1'b0);
    probe(OX + 96 + 29, OY + 6,  4,  29, 6,  1'b1);
    probe(OX + 128,     OY + 5,  10, 0,  0,  1'b0);
    probe(OX - 1,       OY + 5,  10, 0,  0,  1'b0);
    probe(OX + 5,       OY + 39, 1,  5,  39, 1'b1);
    probe(OX + 5,       OY + 40, 10, 0,  0,  1'b0);
    probe(OX + 5,       OY - 1,  10, 0,  0,  1'b0);

    send(12000);
    digits(9, 9, 9, 9);

    send(1005);
    digits(1, 0, 0, 5);

    send(7);
    digits(L, L, L, 7);

    // Reset lands on the 7th CONV cycle of 5555
    chk("ready_pre5555", int'(score_ready), 1);
    score = 14'd5555;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    repeat (6) tick();
    chk("ready_mid_conv", int'(score_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ready_after_rst", int'(score_ready), 1);
    digits(0, 0, 0, 0);

    send(42);
    digits(L, L, 4, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
